// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with a double-buffered display value.
// A new value is loaded at a frame boundary, so a frame never shows a mix of old and new digits.
module seg_scan_ctrl #(
  parameter int NDIG     = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [4*NDIG-1:0] din,
  input  logic              blank_lz,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg,
  output logic              frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
  localparam logic [6:0]    SEG_OFF  = 7'b1111111;

  logic [CW-1:0]     cnt, cnt_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [4*NDIG-1:0] disp, disp_nxt, pend;
  logic              pend_full;
  logic              cnt_wrap, frame_now, frame_nxt, xfer;
  logic [NDIG-1:0]   lz, an_nxt;
  logic [6:0]        seg_nxt;
  logic [3:0]        dig;
  logic              upper_zero;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b0000110;
    endcase
  endfunction

  assign ld_ready  = !pend_full;
  assign xfer      = ld_valid && !pend_full;
  assign cnt_wrap  = (cnt == CNT_LAST);
  assign frame_now = cnt_wrap && (idx == IDX_LAST);

  // Outputs are registered from next-state values so an/seg line up with the cnt/idx of their cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    cnt_nxt    = cnt_wrap ? '0 : cnt + 1'b1;
    idx_nxt    = idx;
    if (cnt_wrap) idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    disp_nxt   = (frame_now && pend_full) ? pend : disp;
    frame_nxt  = (cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);

    upper_zero = 1'b1;
    lz         = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (disp_nxt[4*i +: 4] == 4'd0);
      lz[i]      = upper_zero && (i != 0);
    end

    dig     = disp_nxt[{idx_nxt, 2'b00} +: 4];
    an_nxt  = '1;
    seg_nxt = SEG_OFF;
    if (cnt_nxt != '0) begin
      an_nxt[idx_nxt] = 1'b0;
      if (!(lz[idx_nxt] && blank_lz)) seg_nxt = seg_code(dig);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      disp       <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      an         <= '1;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      disp       <= disp_nxt;
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_done <= frame_nxt;
      if (frame_now && pend_full) pend_full <= 1'b0;
      // A transfer only happens while pend is empty, so it never races the swap above.
      if (xfer) begin
        pend      <= din;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NDIG=8, SCAN_DIV=4): directed scenarios followed by
// randomized loads, blanking and resets, all compared cycle by cycle against a behavioural model.
module tb_seg_scan_ctrl;

  localparam int NDIG     = 8;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] din = '0;
  logic        blank_lz = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Model state: position in the scan plus displayed/pending values.
  int          m_cnt, m_idx;
  logic [31:0] m_disp, m_pend;
  bit          m_full, m_blank;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06};

  seg_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .din(din),
    .blank_lz(blank_lz), .an(an), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg();
    logic [31:0] upper;
    if (m_cnt == 0) return 7'h7F;
    upper = m_disp >> (4 * m_idx);
    if (m_idx > 0 && upper == 0 && m_blank) return 7'h7F;
    return seg_tbl[upper[3:0]];
  endfunction

  // One clock: drive inputs, advance the model with the values seen at the edge, compare outputs.
  task automatic step(input bit r, input bit v, input logic [31:0] d, input bit b);
    bit fd, xf;
    rst = r; ld_valid = v; din = d; blank_lz = b;
    @(posedge clk);
    m_blank = b;
    if (r) begin
      m_cnt = 0; m_idx = 0; m_disp = '0; m_pend = '0; m_full = 0;
    end else begin
      fd = (m_cnt == SCAN_DIV - 1) && (m_idx == NDIG - 1);
      xf = v && !m_full;
      if (fd && m_full) begin m_disp = m_pend; m_full = 0; end
      if (xf) begin m_pend = d; m_full = 1; end
      if (m_cnt == SCAN_DIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % NDIG;
      end else m_cnt++;
    end
    #1;
    check("an", {24'h0, an}, (m_cnt == 0) ? 32'hFF : {24'h0, ~(8'h01 << m_idx)});
    check("seg", {25'h0, seg}, {25'h0, exp_seg()});
    check("frame_done", {31'h0, frame_done}, (m_cnt == SCAN_DIV - 1 && m_idx == NDIG - 1) ? 1 : 0);
    check("ld_ready", {31'h0, ld_ready}, m_full ? 0 : 1);
  endtask

  task automatic idle(input int n, input bit b);
    for (int k = 0; k < n; k++) step(0, 0, '0, b);
  endtask

  // Idles until the next edge is a frame_done cycle, bounded to one frame plus margin.
  task automatic to_frame_edge(input bit b);
    for (int k = 0; k < 2 * NDIG * SCAN_DIV; k++) begin
      if (m_cnt == SCAN_DIV - 1 && m_idx == NDIG - 1) return;
      step(0, 0, '0, b);
    end
  endtask

  task automatic load(input logic [31:0] d, input bit b);
    step(0, 1, d, b);
  endtask

  initial begin
    m_cnt = 0; m_idx = 0; m_disp = '0; m_pend = '0; m_full = 0; m_blank = 0;
    @(negedge clk);
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);

    // Idle scan over two frames.
    idle(64, 0);

    // 0x1234 with blanking, then without.
    load(32'h0000_1234, 1);
    to_frame_edge(1);
    idle(2 * NDIG * SCAN_DIV, 1);
    idle(NDIG * SCAN_DIV, 0);

    // Second offer stalls while the first is pending.
    load(32'h1111_1111, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 32'h2222_2222, 0);
    for (int k = 0; k < 3 * NDIG * SCAN_DIV; k++) step(0, 1, 32'h2222_2222, 0);
    idle(NDIG * SCAN_DIV, 0);

    // Transfer coincident with frame_done while pend is empty.
    to_frame_edge(0);
    load(32'h0000_5678, 0);
    idle(2 * NDIG * SCAN_DIV + 2, 0);

    // Invalid BCD digits and an all-zero value with blanking.
    load(32'hFEDC_BA98, 0);
    idle(2 * NDIG * SCAN_DIV, 0);
    load(32'h0000_0000, 1);
    idle(2 * NDIG * SCAN_DIV, 1);

    // Reset while a value is pending and digit 5 is scanning.
    to_frame_edge(0);
    step(0, 0, '0, 0);
    load(32'h9999_9999, 0);
    for (int k = 0; k < NDIG * SCAN_DIV && !(m_idx == 5 && m_cnt == 2); k++) step(0, 0, '0, 0);
    check("reach_idx5", m_idx, 5);
    step(1, 0, '0, 0);
    idle(3 * NDIG * SCAN_DIV, 0);

    // Random traffic.
    begin
      bit b = 0;
      for (int k = 0; k < 4000; k++) begin
        logic [31:0] d;
        d = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 15) == 0) b = !b;
        step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, d, b);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NDIG, default 8, number of multiplexed 7-segment digits (2..8).
REQ-002 Parameter SCAN_DIV, default 50000, clock cycles each digit is held (>=2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 ld_valid  input  1  new display value offered.
REQ-006 ld_ready  output  1  controller can accept a value; transfer occurs when ld_valid && ld_ready at a rising edge.
REQ-007 din  input  4*NDIG  BCD digits; din[3:0] is digit 0 (least significant, rightmost).
REQ-008 blank_lz  input  1  1 = blank leading zeros.
REQ-009 an  output  NDIG  digit enables, active-low; bit i selects digit i.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 frame_done  output  1  one-cycle pulse when the last digit's slot completes.

Function
REQ-012 SHALL hold a scan counter cnt (0..SCAN_DIV-1) and digit index idx (0..NDIG-1); cnt increments every cycle and wraps SCAN_DIV-1 -> 0.
REQ-013 SHALL advance idx by 1 on the cycle cnt wraps; idx wraps NDIG-1 -> 0.
REQ-014 SHALL assert frame_done for exactly the cycle in which cnt==SCAN_DIV-1 and idx==NDIG-1.
REQ-015 SHALL drive an all-ones (guard blank) in every cycle where cnt==0, to suppress ghosting.
REQ-016 SHALL, when cnt!=0, drive an with only bit idx low.
REQ-017 an and seg SHALL be registered and SHALL reflect, in the same cycle, the cnt/idx values visible in that cycle (computed from next-state, no extra latency).
REQ-018 seg SHALL be the BCD-to-7-segment code of the displayed digit of disp[idx]: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; codes 10..15 = 0000110 ("E").
REQ-019 Digit i (i>=1) SHALL be a leading zero when it and all higher digits of disp equal 0; digit 0 is never a leading zero.
REQ-020 When blank_lz=1, a leading-zero digit SHALL drive seg=1111111 (an unchanged); when blank_lz=0 it shows "0".
REQ-021 seg SHALL be 1111111 in guard cycles (cnt==0).
REQ-022 Load path: displayed register disp plus one pending register pend with flag pend_full.
REQ-023 ld_ready SHALL equal !pend_full (combinational).
REQ-024 On transfer, pend <= din and pend_full <= 1.
REQ-025 On a frame_done cycle with pend_full=1, disp <= pend and pend_full <= 0; displayed value therefore changes only at frame boundaries (no tearing).
REQ-026 Transfer in a frame_done cycle with pend_full=0: value goes to pend only; displayed from the next frame boundary.
REQ-027 ld_valid while ld_ready=0 SHALL be ignored; din SHALL NOT be sampled.
REQ-028 blank_lz is sampled every cycle; changes take effect immediately.

Reset
REQ-029 While rst=1 at a rising edge: cnt=0, idx=0, disp=0, pend=0, pend_full=0.
REQ-030 Outputs after reset: an=all ones, seg=1111111, frame_done=0, ld_ready=1.
REQ-031 Reset mid-frame or with pend_full=1 SHALL discard the pending value; the scan restarts at digit 0 with cnt=0.

Verification (NDIG=8, SCAN_DIV=4)
REQ-032 Reset, idle 64 cycles -> an cycles FE,FD,..,7F, each low 3 of 4 cycles with FF on cnt==0; seg=1000000 on digit 0; frame_done every 32 cycles.
REQ-033 Load din=0x00001234, blank_lz=1 -> after next frame_done: digits 0..3 show 4,3,2,1 codes; digits 4..7 seg=1111111; blank_lz=0 -> digits 4..7 show 1000000.
REQ-034 Load 0x11111111 then offer 0x22222222 before frame_done -> second offer stalled (ld_ready=0); first displayed after boundary, ld_ready returns 1 the cycle after; second accepted and displayed one frame later.
REQ-035 Transfer coincident with frame_done, pend empty -> disp unchanged that frame; new value shown after the following frame_done.
REQ-036 din digit value 0xA..0xF -> seg=0000110 on that digit; 0x00000000 with blank_lz=1 -> only digit 0 shows 1000000.
REQ-037 Assert rst with pend_full=1 at idx=5 -> next cycle an=FF, seg=1111111, ld_ready=1; pending value never displayed.
